// File: rtl/aes_key_scheduler.sv
// AES key expansion (FIPS-197) for 128/192/256-bit keys, streaming one 128-bit
// round key at a time over a valid/ready handshake, two cycles per generated word.

module aes_sbox4 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  output logic [31:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 via an addition chain, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    inv  = gf_mul(gf_mul(a240, a12), a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else for (int b = 0; b < 4; b++) dout[8*b +: 8] <= sbox(din[8*b +: 8]);
  end
endmodule

module aes_key_scheduler #(
  parameter logic [2:0] MODES_EN = 3'b111,
  parameter int         IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic [255:0]     key,
  output logic [127:0]     rk,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [IDX_W-1:0] rk_idx,
  output logic             rk_last,
  output logic             busy,
  output logic             err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_APPLY, S_DRAIN} state_t;
  state_t state, state_n;

  logic [7:0][31:0] win;      // win[7] = w[i-1], win[8-Nk] = w[i-Nk]
  logic [7:0][31:0] kw;
  logic [3:0][31:0] stg;      // stg[3] is the oldest word -> rk[127:96]
  logic [3:0][31:0] stg_n, stg_app, xdata;
  logic [2:0]       stg_cnt, cnt_n;
  logic [5:0]       wi, last_w;
  logic [2:0]       wmod;
  logic [3:0]       nk_q, nr_q;
  logic [7:0]       rcon, rcon_x;
  logic [31:0]      sub_in, sub_out, w_nk, temp, w_new;
  logic             legal, accept, reject, acc, xfer_ok, stall, gen, xfer, finish;

  always_comb begin
    for (int j = 0; j < 8; j++) kw[j] = key[255-32*j -: 32];
  end

  always_comb begin
    case (key_len)
      2'd0:    legal = MODES_EN[0];
      2'd1:    legal = MODES_EN[1];
      2'd2:    legal = MODES_EN[2];
      default: legal = 1'b0;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign accept  = (state == S_IDLE) && start && legal;
  assign reject  = (state == S_IDLE) && start && !legal;
  assign acc     = rk_valid && rk_ready;
  assign xfer_ok = !rk_valid || rk_ready;
  assign rk_last = rk_valid && (rk_idx == IDX_W'(nr_q));
  assign stall   = (stg_cnt == 3'd4) && !xfer_ok;
  assign gen     = (state == S_APPLY) && !stall;
  assign finish  = (state == S_DRAIN) && acc && rk_last;
  assign rcon_x  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  // The S-box input is a pure function of the window, so a stalled APPLY still
  // sees the value fetched for the current word.
  assign sub_in = (wmod == 3'd0) ? {win[7][23:0], win[7][31:24]} : win[7];

  aes_sbox4 u_sbox (.clk(clk), .rst(rst), .din(sub_in), .dout(sub_out));

  always_comb begin
    case (nk_q)
      4'd4:    w_nk = win[4];
      4'd6:    w_nk = win[2];
      default: w_nk = win[0];
    endcase
    if (wmod == 3'd0)                        temp = sub_out ^ {rcon, 24'h0};
    else if (nk_q == 4'd8 && wmod == 3'd4)   temp = sub_out;
    else                                     temp = win[7];
    w_new = w_nk ^ temp;
  end

  // Staging: a word completing the buffer may go straight to rk in the same cycle.
  always_comb begin
    stg_n   = stg;
    stg_app = stg;
    cnt_n   = stg_cnt;
    xdata   = stg;
    xfer    = 1'b0;
    if (gen && stg_cnt < 3'd4) stg_app[2'(3'd3 - stg_cnt)] = w_new;
    if (stg_cnt == 3'd4) begin
      if (xfer_ok) begin
        xfer  = 1'b1;
        cnt_n = gen ? 3'd1 : 3'd0;
        if (gen) stg_n[3] = w_new;
      end
    end else if (gen) begin
      if (stg_cnt == 3'd3 && xfer_ok) begin
        xfer  = 1'b1;
        xdata = stg_app;
        cnt_n = 3'd0;
      end else begin
        stg_n = stg_app;
        cnt_n = stg_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // LOAD doubles as the FETCH of the first generated word.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:          if (accept) state_n = S_LOAD;
      S_LOAD, S_FETCH: if (!stall) state_n = S_APPLY;
      S_APPLY:         if (!stall) state_n = (wi == last_w) ? S_DRAIN : S_FETCH;
      S_DRAIN:         if (finish) state_n = S_IDLE;
      default:         state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win      <= '0;
      stg      <= '0;
      stg_cnt  <= '0;
      wi       <= '0;
      last_w   <= '0;
      wmod     <= '0;
      nk_q     <= '0;
      nr_q     <= '0;
      rcon     <= 8'h01;
      rk       <= '0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      err      <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        rcon     <= 8'h01;
        wmod     <= '0;
        rk       <= {kw[0], kw[1], kw[2], kw[3]};
        rk_valid <= 1'b1;
        rk_idx   <= '0;
        win      <= '0;
        case (key_len)
          2'd0: begin
            nk_q <= 4'd4; nr_q <= 4'd10; wi <= 6'd4; last_w <= 6'd43;
            for (int j = 0; j < 4; j++) win[4+j] <= kw[j];
            stg <= '0; stg_cnt <= 3'd0;
          end
          2'd1: begin
            nk_q <= 4'd6; nr_q <= 4'd12; wi <= 6'd6; last_w <= 6'd51;
            for (int j = 0; j < 6; j++) win[2+j] <= kw[j];
            stg <= {kw[4], kw[5], 64'h0}; stg_cnt <= 3'd2;
          end
          default: begin
            nk_q <= 4'd8; nr_q <= 4'd14; wi <= 6'd8; last_w <= 6'd59;
            for (int j = 0; j < 8; j++) win[j] <= kw[j];
            stg <= {kw[4], kw[5], kw[6], kw[7]}; stg_cnt <= 3'd4;
          end
        endcase
      end else begin
        if (gen) begin
          for (int j = 0; j < 7; j++) win[j] <= win[j+1];
          win[7] <= w_new;
          wi     <= wi + 6'd1;
          wmod   <= ({1'b0, wmod} == nk_q - 4'd1) ? 3'd0 : wmod + 3'd1;
          if (wmod == 3'd0) rcon <= rcon_x;
        end
        stg     <= stg_n;
        stg_cnt <= cnt_n;
        if (xfer) begin
          rk       <= xdata;
          rk_valid <= 1'b1;
          rk_idx   <= rk_idx + IDX_W'(1);
        end else if (finish) begin
          rk_valid <= 1'b0;
          rk_idx   <= '0;
        end else if (acc) begin
          rk_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/aes_key_scheduler.md
AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 SHALL have parameter MODES_EN, default 3'b111, bit-mask of supported key lengths (bit0=128, bit1=192, bit2=256).
REQ-002 SHALL have parameter IDX_W, default 4, width of the round-key index output.
REQ-003 SHALL have port clk  input  1  clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request key expansion, sampled each cycle.
REQ-006 SHALL have port key_len  input  2  0=128, 1=192, 2=256, 3=illegal.
REQ-007 SHALL have port key  input  256  cipher key, MSB-aligned; 128-bit key in key[255:128], 192-bit key in key[255:64].
REQ-008 SHALL have port rk  output  128  current round key, word w[4i] in rk[127:96].
REQ-009 SHALL have port rk_valid  output  1  rk holds a valid round key.
REQ-010 SHALL have port rk_ready  input  1  consumer accepts rk this cycle.
REQ-011 SHALL have port rk_idx  output  IDX_W  round number i of rk.
REQ-012 SHALL have port rk_last  output  1  rk is round key Nr.
REQ-013 SHALL have port busy  output  1  expansion in progress.
REQ-014 SHALL have port err  output  1  one-cycle pulse on rejected start.

Function
REQ-015 SHALL derive Nk/Nr from key_len as 4/10, 6/12 and 8/14, latched on start acceptance.
REQ-016 SHALL accept start only when busy=0, rst=0 and key_len is legal and enabled in MODES_EN.
REQ-017 SHALL ignore start while busy=1, with no effect on the run in progress and no err.
REQ-018 SHALL pulse err for 1 cycle on an illegal or disabled key_len when busy=0, leaving busy at 0.
REQ-019 SHALL, in the acceptance cycle, load w[0..Nk-1] from key into an 8-word window and assert busy on the next edge.
REQ-020 SHALL present rk0 = w[0..3] with rk_valid=1 and rk_idx=0 in the cycle after acceptance.
REQ-021 SHALL generate words w[Nk] to w[4Nr+3] one at a time, at exactly 2 cycles per word (FETCH, APPLY), without generating words beyond w[4Nr+3].
REQ-022 SHALL compute each generated word per FIPS-197:
- i mod Nk = 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}.
- Nk = 8 and i mod 8 = 4: temp = SubWord(w[i-1]).
- otherwise: temp = w[i-1].
- w[i] = w[i-Nk] ^ temp.
REQ-023 SHALL perform SubWord with the codebase's registered 4-byte S-box (1-cycle latency) in the FETCH cycle.
REQ-024 SHALL start Rcon at 8'h01 and update it with xtime after each use, so that 8'h80 is followed by 8'h1b.
REQ-025 SHALL assemble generated words into a 4-word staging buffer and transfer it to the rk register when complete and the rk register is empty or being accepted in the same cycle.
REQ-026 SHALL stall word generation with no state change when staging is complete and rk_valid=1 and rk_ready=0.
REQ-027 SHALL hold rk, rk_idx and rk_last stable while rk_valid=1 and rk_ready=0.
REQ-028 SHALL assert rk_last exactly with rk_idx=Nr.
REQ-029 SHALL deassert busy and rk_valid on the edge where rk_last is accepted; a start in that same cycle SHALL be ignored.
REQ-030 SHALL, with rk_ready held at 1, make rk_i valid at cycle 1+8i after acceptance for AES-128, and make rk_Nr valid at cycles 81, 93 and 105 for AES-128, 192 and 256.
REQ-031 SHALL implement the FSM IDLE -> LOAD -> FETCH <-> APPLY -> DRAIN -> IDLE, with DRAIN waiting for the final accept.

Reset
REQ-032 SHALL, on rst=1, force the FSM to IDLE, rk=0, rk_valid=0, rk_idx=0, rk_last=0, busy=0, err=0, Rcon=8'h01 and the window to 0.
REQ-033 SHALL abandon a run when rst is asserted mid-operation, emit no further round keys, and accept start on the first cycle after rst deasserts.

Verification
REQ-034 SHALL cover: AES-128 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1 -> rk10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 at cycle 81, with rk_last=1.
REQ-035 SHALL cover: AES-192 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> rk12 = e98ba06f 448c773c 8ecc7204 01002202 at cycle 93.
REQ-036 SHALL cover: AES-256 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, random rk_ready -> rk14 = fe4890d1 e6188d0b 046df344 706c631e, with all 15 keys in order and rk stable while stalled.
REQ-037 SHALL cover: key_len=3, and key_len=1 with MODES_EN=3'b101 -> one err pulse each, busy stays 0 and no rk_valid.
REQ-038 SHALL cover: start pulsed at cycle 20 of an AES-128 run -> ignored and run output unchanged.
REQ-039 SHALL cover: rst asserted at cycle 40 of a run -> all outputs 0 next cycle, and a new start then yields correct rk0 one cycle after acceptance.
